// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: grant/owner codes and
// memory transfer sizes.
package mem_bus_arbiter_pkg;

    // Grant / owner encodings
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IC   = 2'b01;
    localparam logic [1:0] OWNER_DC   = 2'b10;

    // data_size encodings
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arb_pick.sv
// Combinational grant picker. A held lock wins outright; otherwise DC has
// fixed priority unless fair_force hands a contended cycle to IC.
module mem_bus_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       ic_act_i,
    input  logic       dc_act_i,
    input  logic       lock_i,
    input  logic       lock_owner_i,
    input  logic       fair_force_i,
    output logic [1:0] grant_o
);

    // Priority: lock, then contention rule, then the single active requester
    always_comb begin
        grant_o = OWNER_NONE;
        if (lock_i) begin
            grant_o = lock_owner_i ? OWNER_DC : OWNER_IC;
        end else if (ic_act_i && dc_act_i) begin
            grant_o = fair_force_i ? OWNER_IC : OWNER_DC;
        end else if (dc_act_i) begin
            grant_o = OWNER_DC;
        end else if (ic_act_i) begin
            grant_o = OWNER_IC;
        end
    end

endmodule : mem_bus_arb_pick

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between instruction fetch (IC, read-only) and the
// memory stage (DC, read/write). Grant is combinational from the current
// requests plus a registered lock, so a granted request reaches the bus in
// the same cycle. A transfer keeps the bus until rw_wait drops.
// Optional build macro MEM_BUS_ARB_FAIRNESS_EN: after MAX_DC_RUN unlocked
// DC wins against a waiting IC, the next contended cycle goes to IC.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DC_RUN = 4,
    parameter int unsigned RUN_W      = 3
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] ic_busaddr,
    input  logic        ic_rd_req,
    output logic        ic_rw_wait,
    output logic [31:0] ic_rd_data,
    input  logic [31:0] dc_busaddr,
    input  logic        dc_rd_req,
    input  logic        dc_wr_req,
    input  logic [31:0] dc_wr_data,
    input  logic [2:0]  dc_data_size,
    output logic        dc_rw_wait,
    output logic [31:0] dc_rd_data,
    output logic [31:0] busaddr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] wr_data,
    output logic [2:0]  data_size,
    input  logic        rw_wait,
    input  logic [31:0] rd_data,
    output logic [1:0]  owner,
    output logic        proto_err
);

    // The run counter must be able to reach MAX_DC_RUN
    if (MAX_DC_RUN >= (1 << RUN_W)) begin : g_bad_cfg
        $error("RUN_W too narrow for MAX_DC_RUN");
    end

    logic       ic_act;
    logic       dc_act;
    logic       fair_force;
    logic [1:0] grant;
    logic       grant_act;

    logic       lock_q, lock_d;
    logic       lock_owner_q, lock_owner_d;
    logic [1:0] owner_q, owner_d;
    logic       proto_err_q, proto_err_d;

    assign ic_act = ic_rd_req;
    assign dc_act = dc_rd_req | dc_wr_req;

    mem_bus_arb_pick u_pick (
        .ic_act_i     (ic_act),
        .dc_act_i     (dc_act),
        .lock_i       (lock_q),
        .lock_owner_i (lock_owner_q),
        .fair_force_i (fair_force),
        .grant_o      (grant)
    );

    // Low when the lock owner has abandoned its request mid-transfer
    assign grant_act = ((grant == OWNER_IC) && ic_act) || ((grant == OWNER_DC) && dc_act);

`ifdef MEM_BUS_ARB_FAIRNESS_EN
    logic [RUN_W-1:0] run_q, run_d;

    assign fair_force = (run_q == RUN_W'(MAX_DC_RUN));

    // Count unlocked DC wins while IC is kept waiting
    always_comb begin
        run_d = run_q;
        if (!ic_act || (grant == OWNER_IC)) begin
            run_d = '0;
        end else if (!lock_q && (grant == OWNER_DC)) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    // Run counter register
    always_ff @(posedge clk) begin
        if (!Nrst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    // Forward the granted requester's fields; reset gates bus requests off
    always_comb begin
        busaddr    = '0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        wr_data    = '0;
        data_size  = '0;
        ic_rw_wait = ic_act;
        dc_rw_wait = dc_act;
        unique case (grant)
            OWNER_IC: begin
                busaddr    = ic_busaddr;
                rd_req     = ic_rd_req;
                data_size  = SIZE_WORD;
                ic_rw_wait = rw_wait;
            end
            OWNER_DC: begin
                busaddr    = dc_busaddr;
                rd_req     = dc_rd_req;
                wr_req     = dc_wr_req;
                wr_data    = dc_wr_data;
                data_size  = dc_data_size;
                dc_rw_wait = rw_wait;
            end
            default: ;
        endcase
        if (!Nrst) begin
            rd_req     = 1'b0;
            wr_req     = 1'b0;
            ic_rw_wait = 1'b1;
            dc_rw_wait = 1'b1;
        end
    end

    assign ic_rd_data = rd_data;
    assign dc_rd_data = rd_data;

    // Lock, owner and protocol-error next state
    always_comb begin
        lock_d       = grant_act && rw_wait;
        lock_owner_d = lock_owner_q;
        if (grant_act && rw_wait) begin
            lock_owner_d = (grant == OWNER_DC);
        end
        owner_d     = grant;
        proto_err_d = proto_err_q | (lock_q & ~grant_act);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!Nrst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            owner_q      <= OWNER_NONE;
            proto_err_q  <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            owner_q      <= owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign owner     = owner_q;
    assign proto_err = proto_err_q;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: the stimulus pushes the expected
// bus/wait/owner values for each driven cycle; a monitor pops and compares
// at the falling edge.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        Nrst;
    logic [31:0] ic_busaddr, dc_busaddr, dc_wr_data, rd_data;
    logic        ic_rd_req, dc_rd_req, dc_wr_req, rw_wait;
    logic [2:0]  dc_data_size;
    logic        ic_rw_wait, dc_rw_wait, rd_req, wr_req, proto_err;
    logic [31:0] ic_rd_data, dc_rd_data, busaddr, wr_data;
    logic [2:0]  data_size;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .Nrst         (Nrst),
        .ic_busaddr   (ic_busaddr),
        .ic_rd_req    (ic_rd_req),
        .ic_rw_wait   (ic_rw_wait),
        .ic_rd_data   (ic_rd_data),
        .dc_busaddr   (dc_busaddr),
        .dc_rd_req    (dc_rd_req),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_data   (dc_wr_data),
        .dc_data_size (dc_data_size),
        .dc_rw_wait   (dc_rw_wait),
        .dc_rd_data   (dc_rd_data),
        .busaddr      (busaddr),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .data_size    (data_size),
        .rw_wait      (rw_wait),
        .rd_data      (rd_data),
        .owner        (owner),
        .proto_err    (proto_err)
    );

    typedef struct {
        string       name;
        bit [31:0]   addr;
        bit          addr_en;
        bit          rd, wr, icw, dcw;
        bit [1:0]    own;
        bit          perr;
        bit [31:0]   wdata;
        bit          wdata_en;
        bit [2:0]    size;
        bit          size_en;
        bit [31:0]   rdata;
        bit          rdata_en;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(string name, bit [31:0] addr, bit addr_en, bit rd, bit wr,
                                bit icw, bit dcw, bit [1:0] own, bit perr);
        exp_t e;
        e.name = name; e.addr = addr; e.addr_en = addr_en;
        e.rd = rd; e.wr = wr; e.icw = icw; e.dcw = dcw; e.own = own; e.perr = perr;
        e.wdata = '0; e.wdata_en = 1'b0; e.size = '0; e.size_en = 1'b0;
        e.rdata = '0; e.rdata_en = 1'b0;
        return e;
    endfunction

    task automatic chk(string name, string field, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.addr_en) chk(e.name, "busaddr", busaddr, e.addr);
            chk(e.name, "rd_req", 32'(rd_req), 32'(e.rd));
            chk(e.name, "wr_req", 32'(wr_req), 32'(e.wr));
            chk(e.name, "ic_rw_wait", 32'(ic_rw_wait), 32'(e.icw));
            chk(e.name, "dc_rw_wait", 32'(dc_rw_wait), 32'(e.dcw));
            chk(e.name, "owner", 32'(owner), 32'(e.own));
            chk(e.name, "proto_err", 32'(proto_err), 32'(e.perr));
            if (e.wdata_en) chk(e.name, "wr_data", wr_data, e.wdata);
            if (e.size_en) chk(e.name, "data_size", 32'(data_size), 32'(e.size));
            if (e.rdata_en) begin
                chk(e.name, "ic_rd_data", ic_rd_data, e.rdata);
                chk(e.name, "dc_rd_data", dc_rd_data, e.rdata);
            end
        end
    end

    task automatic step(exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        bit [1:0] prev;
        bit ic_win;
        Nrst = 1'b0; ic_busaddr = '0; ic_rd_req = 1'b0; dc_busaddr = '0;
        dc_rd_req = 1'b0; dc_wr_req = 1'b0; dc_wr_data = '0; dc_data_size = SIZE_WORD;
        rw_wait = 1'b0; rd_data = '0;
        @(posedge clk); #1;

        // Reset: requests gated, both waits high
        step(mk("reset", 0, 0, 0, 0, 1, 1, OWNER_NONE, 0));
        Nrst = 1'b1;
        step(mk("idle", 0, 0, 0, 0, 0, 0, OWNER_NONE, 0));

        // IC-only read, two wait cycles
        ic_rd_req = 1'b1; ic_busaddr = 32'h100; rw_wait = 1'b1;
        e = mk("ic_rd_w1", 32'h100, 1, 1, 0, 1, 0, OWNER_NONE, 0);
        e.size = SIZE_WORD; e.size_en = 1'b1;
        step(e);
        step(mk("ic_rd_w2", 32'h100, 1, 1, 0, 1, 0, OWNER_IC, 0));
        rw_wait = 1'b0; rd_data = 32'hE3A00001;
        e = mk("ic_rd_done", 32'h100, 1, 1, 0, 0, 0, OWNER_IC, 0);
        e.rdata = 32'hE3A00001; e.rdata_en = 1'b1;
        step(e);
        ic_rd_req = 1'b0;
        step(mk("ic_idle", 0, 0, 0, 0, 0, 0, OWNER_IC, 0));

        // Contention: DC write wins, IC follows immediately after completion
        ic_rd_req = 1'b1; ic_busaddr = 32'h104;
        dc_wr_req = 1'b1; dc_busaddr = 32'h200; dc_wr_data = 32'hDEADBEEF;
        dc_data_size = SIZE_WORD; rw_wait = 1'b1;
        e = mk("cont_dc_w", 32'h200, 1, 0, 1, 1, 1, OWNER_NONE, 0);
        e.wdata = 32'hDEADBEEF; e.wdata_en = 1'b1; e.size = SIZE_WORD; e.size_en = 1'b1;
        step(e);
        rw_wait = 1'b0;
        step(mk("cont_dc_done", 32'h200, 1, 0, 1, 1, 0, OWNER_DC, 0));
        dc_wr_req = 1'b0; rw_wait = 1'b1;
        step(mk("cont_ic_gnt", 32'h104, 1, 1, 0, 1, 0, OWNER_DC, 0));

        // Lock hold: DC requests mid IC transfer and must wait
        dc_rd_req = 1'b1; dc_busaddr = 32'h300; dc_data_size = SIZE_BYTE;
        step(mk("hold_1", 32'h104, 1, 1, 0, 1, 1, OWNER_IC, 0));
        step(mk("hold_2", 32'h104, 1, 1, 0, 1, 1, OWNER_IC, 0));
        step(mk("hold_3", 32'h104, 1, 1, 0, 1, 1, OWNER_IC, 0));
        rw_wait = 1'b0;
        step(mk("hold_done", 32'h104, 1, 1, 0, 0, 1, OWNER_IC, 0));
        ic_rd_req = 1'b0; rw_wait = 1'b1;
        e = mk("hold_dc_gnt", 32'h300, 1, 1, 0, 0, 1, OWNER_IC, 0);
        e.size = SIZE_BYTE; e.size_en = 1'b1;
        step(e);

        // Abort: locked DC drops its request
        dc_rd_req = 1'b0;
        step(mk("abort", 0, 0, 0, 0, 0, 1, OWNER_DC, 0));
        ic_rd_req = 1'b1; ic_busaddr = 32'h400; rw_wait = 1'b0;
        step(mk("abort_unlock", 32'h400, 1, 1, 0, 0, 0, OWNER_DC, 1));
        ic_rd_req = 1'b0;

        // Reset during a locked DC read
        dc_rd_req = 1'b1; dc_busaddr = 32'h500; dc_data_size = SIZE_WORD; rw_wait = 1'b1;
        step(mk("rst_dc_gnt", 32'h500, 1, 1, 0, 0, 1, OWNER_IC, 1));
        Nrst = 1'b0;
        step(mk("rst_mid", 0, 0, 0, 0, 1, 1, OWNER_DC, 1));
        Nrst = 1'b1; dc_rd_req = 1'b0; ic_rd_req = 1'b1; ic_busaddr = 32'h600;
        rw_wait = 1'b0;
        step(mk("rst_after", 32'h600, 1, 1, 0, 0, 0, OWNER_NONE, 0));
        ic_rd_req = 1'b0;
        step(mk("rst_idle", 0, 0, 0, 0, 0, 0, OWNER_IC, 0));

        // Continuous contention, every transfer single-cycle
        ic_rd_req = 1'b1; ic_busaddr = 32'h700;
        dc_rd_req = 1'b1; dc_busaddr = 32'h800; rw_wait = 1'b0;
        prev = OWNER_NONE;
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_BUS_ARB_FAIRNESS_EN
            ic_win = ((k % 5) == 4);
`else
            ic_win = 1'b0;
`endif
            step(mk($sformatf("fair_%0d", k), ic_win ? 32'h700 : 32'h800, 1, 1, 0,
                    !ic_win, ic_win, prev, 0));
            prev = ic_win ? OWNER_IC : OWNER_DC;
        end
        ic_rd_req = 1'b0; dc_rd_req = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
